// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module   : reg_scoreboard
// Purpose  : Per-register write scoreboard for the 5-stage pipeline. Tracks
//            all in-flight writers and the subset whose long-latency result
//            (load / CSR read / divide) is not yet forwardable, and stalls ID
//            when a source operand depends on such a result.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    issue_valid,
  input  logic                    issue_we,
  input  logic [$clog2(NREG)-1:0] issue_waddr,
  input  logic                    issue_long,
  input  logic                    avail_valid,
  input  logic [$clog2(NREG)-1:0] avail_waddr,
  input  logic                    wb_valid,
  input  logic                    wb_we,
  input  logic [$clog2(NREG)-1:0] wb_waddr,
  input  logic                    flush,
  input  logic                    rs1_re,
  input  logic [$clog2(NREG)-1:0] rs1,
  input  logic                    rs2_re,
  input  logic [$clog2(NREG)-1:0] rs2,
  output logic                    id_stall,
  output logic                    pend_any,
  output logic                    err_flag
);

  localparam int              AW      = $clog2(NREG);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Read-side views of the counters; index 0 is hard-wired to zero.
  logic [CNT_W-1:0] w_pend_view [NREG];
  logic [CNT_W-1:0] w_long_view [NREG];
  // Per-register saturation event this cycle (overflow or underflow).
  logic [NREG-1:0]  w_err;
  logic             w_err_any;
  logic             w_pend_any;
  logic             r_err;

  assign w_pend_view[0] = '0;
  assign w_long_view[0] = '0;
  assign w_err[0]       = 1'b0;

  genvar gr;
  generate
    for (gr = 1; gr < NREG; gr++) begin : g_reg
      logic [CNT_W-1:0] r_pend;
      logic [CNT_W-1:0] r_long;
      logic             w_pend_inc;
      logic             w_pend_dec;
      logic             w_long_inc;
      logic             w_long_dec;
      logic             w_pend_bad;
      logic             w_long_bad;

      assign w_pend_inc = issue_valid & issue_we & (issue_waddr == AW'(gr));
      assign w_long_inc = w_pend_inc & issue_long;
      assign w_long_dec = avail_valid & (avail_waddr == AW'(gr));
      assign w_pend_dec = wb_valid & wb_we & (wb_waddr == AW'(gr));

      // A lone inc at max or lone dec at zero is a saturation event; a flush
      // discards the same-cycle inc/dec, so it raises no error either.
      assign w_pend_bad = (w_pend_inc & ~w_pend_dec & (r_pend == CNT_MAX)) |
                          (w_pend_dec & ~w_pend_inc & (r_pend == '0));
      assign w_long_bad = (w_long_inc & ~w_long_dec & (r_long == CNT_MAX)) |
                          (w_long_dec & ~w_long_inc & (r_long == '0));
      assign w_err[gr]  = ~flush & (w_pend_bad | w_long_bad);

      // Pending-write counter: flush clears, inc+dec nets to hold, saturating.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_pend <= '0;
        end else if (flush) begin
          r_pend <= '0;
        end else if (w_pend_inc & ~w_pend_dec) begin
          if (r_pend != CNT_MAX) r_pend <= r_pend + 1'b1;
        end else if (w_pend_dec & ~w_pend_inc) begin
          if (r_pend != '0) r_pend <= r_pend - 1'b1;
        end
      end

      // Long-latency counter: same update rules, released by avail.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_long <= '0;
        end else if (flush) begin
          r_long <= '0;
        end else if (w_long_inc & ~w_long_dec) begin
          if (r_long != CNT_MAX) r_long <= r_long + 1'b1;
        end else if (w_long_dec & ~w_long_inc) begin
          if (r_long != '0) r_long <= r_long - 1'b1;
        end
      end

      assign w_pend_view[gr] = r_pend;
      assign w_long_view[gr] = r_long;
    end
  endgenerate

  // Reduce per-register state to the pipe-drain indication and error event.
  always_comb begin
    w_pend_any = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      w_pend_any = w_pend_any | (w_pend_view[r] != '0);
    end
    w_err_any = |w_err;
  end

  // Sticky error flag: only reset clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err <= 1'b0;
    end else if (w_err_any) begin
      r_err <= 1'b1;
    end
  end

  // Stall depends only on registered counters and ID source fields.
  assign id_stall = (rs1_re & (rs1 != '0) & (w_long_view[rs1] != '0)) |
                    (rs2_re & (rs2 != '0) & (w_long_view[rs2] != '0));
  assign pend_any = w_pend_any;
  assign err_flag = r_err;

endmodule

`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
// ============================================================================
// Module   : tb_reg_scoreboard
// Purpose  : Self-checking bench for reg_scoreboard: directed scenarios plus
//            randomized traffic against a per-register count model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       resetn;
  logic       issue_valid, issue_we, issue_long;
  logic [4:0] issue_waddr;
  logic       avail_valid;
  logic [4:0] avail_waddr;
  logic       wb_valid, wb_we;
  logic [4:0] wb_waddr;
  logic       flush;
  logic       rs1_re, rs2_re;
  logic [4:0] rs1, rs2;
  logic       id_stall, pend_any, err_flag;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: plain integer counts per register.
  int pend_m [32];
  int long_m [32];
  bit err_m;

  always #5 clk = ~clk;

  reg_scoreboard #(.NREG(32), .CNT_W(2)) dut (
    .clk(clk), .resetn(resetn),
    .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_waddr(issue_waddr), .issue_long(issue_long),
    .avail_valid(avail_valid), .avail_waddr(avail_waddr),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_waddr(wb_waddr),
    .flush(flush),
    .rs1_re(rs1_re), .rs1(rs1), .rs2_re(rs2_re), .rs2(rs2),
    .id_stall(id_stall), .pend_any(pend_any), .err_flag(err_flag)
  );

  function automatic void model_clear();
    foreach (pend_m[r]) begin pend_m[r] = 0; long_m[r] = 0; end
  endfunction

  // Counter of range 0..3: one-sided change, clipped; both-sided holds.
  function automatic int next_cnt(int c, bit inc, bit dec);
    if (inc && !dec) return (c == 3) ? c : c + 1;
    if (dec && !inc) return (c == 0) ? c : c - 1;
    return c;
  endfunction

  function automatic bit sat_event(int c, bit inc, bit dec);
    return (inc && !dec && c == 3) || (dec && !inc && c == 0);
  endfunction

  function automatic void model_step();
    if (flush) begin
      model_clear();
      return;
    end
    for (int r = 1; r < 32; r++) begin
      bit pi, li, pd, ld;
      pi = issue_valid && issue_we && (issue_waddr == r);
      li = pi && issue_long;
      ld = avail_valid && (avail_waddr == r);
      pd = wb_valid && wb_we && (wb_waddr == r);
      if (sat_event(pend_m[r], pi, pd) || sat_event(long_m[r], li, ld)) err_m = 1'b1;
      pend_m[r] = next_cnt(pend_m[r], pi, pd);
      long_m[r] = next_cnt(long_m[r], li, ld);
    end
  endfunction

  function automatic bit exp_stall();
    return (rs1_re && rs1 != 0 && long_m[rs1] != 0) ||
           (rs2_re && rs2 != 0 && long_m[rs2] != 0);
  endfunction

  function automatic bit exp_pend_any();
    bit a = 1'b0;
    for (int r = 1; r < 32; r++) if (pend_m[r] != 0) a = 1'b1;
    return a;
  endfunction

  task automatic idle_inputs();
    issue_valid = 0; issue_we = 0; issue_long = 0; issue_waddr = 0;
    avail_valid = 0; avail_waddr = 0;
    wb_valid = 0; wb_we = 0; wb_waddr = 0;
    flush = 0;
  endtask

  // Advance one clock, update the model from the sampled inputs, drop pulses.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    rs1_re = 0; rs1 = 0; rs2_re = 0; rs2 = 0;
    resetn = 0;
    model_clear();
    err_m = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1;
    #1;
  endtask

  task automatic issue(input logic [4:0] r, input logic lng);
    issue_valid = 1; issue_we = 1; issue_waddr = r; issue_long = lng;
  endtask

  task automatic retire(input logic [4:0] r);
    wb_valid = 1; wb_we = 1; wb_waddr = r;
  endtask

  task automatic avail(input logic [4:0] r);
    avail_valid = 1; avail_waddr = r;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({id_stall, pend_any, err_flag} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_outputs: got stall/pend/err=%b want 000", {id_stall, pend_any, err_flag});
    end
  endtask

  task automatic test_load_stall();
    do_reset();
    rs1_re = 1; rs1 = 5;
    issue(5, 1); #1;
    vectors++;
    if (id_stall !== 1'b0) begin miscompares++; $display("FAIL load_c1_stall: got %b want 0", id_stall); end
    tick();
    vectors++;
    if (id_stall !== 1'b1) begin miscompares++; $display("FAIL load_c2_stall: got %b want 1", id_stall); end
    tick();
    avail(5); #1;
    vectors++;
    if (id_stall !== 1'b1) begin miscompares++; $display("FAIL load_c3_stall: got %b want 1", id_stall); end
    tick();
    retire(5); #1;
    vectors++;
    if (id_stall !== 1'b0) begin miscompares++; $display("FAIL load_c4_stall: got %b want 0", id_stall); end
    vectors++;
    if (pend_any !== 1'b1) begin miscompares++; $display("FAIL load_c4_pend: got %b want 1", pend_any); end
    tick();
    vectors++;
    if (pend_any !== 1'b0) begin miscompares++; $display("FAIL load_c5_pend: got %b want 0", pend_any); end
  endtask

  task automatic test_short_write();
    do_reset();
    issue(7, 0);
    tick();
    rs1_re = 1; rs1 = 7; #1;
    vectors++;
    if ({id_stall, pend_any} !== 2'b01) begin
      miscompares++; $display("FAIL short_pending: got stall/pend=%b want 01", {id_stall, pend_any});
    end
    retire(7); #1;
    vectors++;
    if (pend_any !== 1'b1) begin miscompares++; $display("FAIL short_retire_cycle: got %b want 1", pend_any); end
    tick();
    vectors++;
    if ({id_stall, pend_any} !== 2'b00) begin
      miscompares++; $display("FAIL short_after_wb: got stall/pend=%b want 00", {id_stall, pend_any});
    end
  endtask

  task automatic test_r0();
    do_reset();
    issue(0, 1);
    rs2_re = 1; rs2 = 0;
    tick();
    avail(0); retire(0);
    tick();
    vectors++;
    if ({id_stall, pend_any, err_flag} !== 3'b000) begin
      miscompares++; $display("FAIL r0_untracked: got stall/pend/err=%b want 000", {id_stall, pend_any, err_flag});
    end
  endtask

  task automatic test_saturation();
    do_reset();
    rs1_re = 1; rs1 = 3;
    repeat (3) begin issue(3, 1); tick(); end
    vectors++;
    if ({id_stall, err_flag} !== 2'b10) begin
      miscompares++; $display("FAIL sat_three: got stall/err=%b want 10", {id_stall, err_flag});
    end
    issue(3, 1); tick();
    vectors++;
    if (err_flag !== 1'b1) begin miscompares++; $display("FAIL sat_overflow_err: got %b want 1", err_flag); end
    repeat (2) begin avail(3); retire(3); tick(); end
    vectors++;
    if ({id_stall, pend_any} !== 2'b11) begin
      miscompares++; $display("FAIL sat_held_at_max: got stall/pend=%b want 11", {id_stall, pend_any});
    end
    avail(3); retire(3); tick();
    vectors++;
    if ({id_stall, pend_any} !== 2'b00) begin
      miscompares++; $display("FAIL sat_drained: got stall/pend=%b want 00", {id_stall, pend_any});
    end
    retire(3); tick();
    vectors++;
    if ({pend_any, err_flag} !== 2'b01) begin
      miscompares++; $display("FAIL sat_underflow: got pend/err=%b want 01", {pend_any, err_flag});
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    rs1_re = 1; rs1 = 9;
    issue(9, 1); tick();
    issue(9, 1); avail(9); retire(9); tick();
    vectors++;
    if ({id_stall, pend_any, err_flag} !== 3'b110) begin
      miscompares++; $display("FAIL same_cycle_hold: got stall/pend/err=%b want 110", {id_stall, pend_any, err_flag});
    end
    avail(9); retire(9); tick();
    vectors++;
    if ({id_stall, pend_any, err_flag} !== 3'b000) begin
      miscompares++; $display("FAIL same_cycle_drain: got stall/pend/err=%b want 000", {id_stall, pend_any, err_flag});
    end
  endtask

  task automatic test_flush_reset();
    do_reset();
    issue(4, 1); tick();
    issue(6, 1); tick();
    rs1_re = 1; rs1 = 4; rs2_re = 1; rs2 = 6; #1;
    vectors++;
    if (id_stall !== 1'b1) begin miscompares++; $display("FAIL flush_pre_stall: got %b want 1", id_stall); end
    flush = 1; issue(8, 1); tick();
    vectors++;
    if ({id_stall, pend_any, err_flag} !== 3'b000) begin
      miscompares++; $display("FAIL flush_clear: got stall/pend/err=%b want 000", {id_stall, pend_any, err_flag});
    end
    rs1 = 8; #1;
    vectors++;
    if (id_stall !== 1'b0) begin miscompares++; $display("FAIL flush_drop_r8: got %b want 0", id_stall); end
    issue(8, 1); tick();
    vectors++;
    if (id_stall !== 1'b1) begin miscompares++; $display("FAIL reset_pre_stall: got %b want 1", id_stall); end
    #2 resetn = 0;
    #1;
    vectors++;
    if ({id_stall, pend_any} !== 2'b00) begin
      miscompares++; $display("FAIL async_reset: got stall/pend=%b want 00", {id_stall, pend_any});
    end
    model_clear();
    err_m = 1'b0;
    @(negedge clk);
    resetn = 1;
    #1;
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      int r;
      idle_inputs();
      r = $urandom_range(0, 31);
      if ($urandom_range(0, 2) != 0 && (pend_m[r] < 3 || $urandom_range(0, 60) == 0)) begin
        issue_valid = 1; issue_we = $urandom_range(0, 4) != 0;
        issue_waddr = 5'(r); issue_long = $urandom_range(0, 1);
      end else begin
        issue_waddr = 5'($urandom);
      end
      r = $urandom_range(1, 31);
      if (long_m[r] > 0 || $urandom_range(0, 80) == 0) begin
        avail_valid = $urandom_range(0, 1); avail_waddr = 5'(r);
      end
      r = $urandom_range(1, 31);
      if (pend_m[r] > long_m[r] || $urandom_range(0, 80) == 0) begin
        wb_valid = $urandom_range(0, 1); wb_we = 1; wb_waddr = 5'(r);
      end
      flush = ($urandom_range(0, 49) == 0);
      rs1_re = $urandom_range(0, 1); rs1 = 5'($urandom);
      rs2_re = $urandom_range(0, 1); rs2 = 5'($urandom);
      #1;
      vectors++;
      if ({id_stall, pend_any, err_flag} !== {exp_stall(), exp_pend_any(), err_m}) begin
        miscompares++;
        $display("FAIL rand_cycle%0d: got stall/pend/err=%b want %b", cyc,
                 {id_stall, pend_any, err_flag}, {exp_stall(), exp_pend_any(), err_m});
      end
      // Bench-side invariant on the traffic it generates.
      for (int k = 1; k < 32; k++) begin
        if (long_m[k] > pend_m[k] && !err_m) begin
          vectors++; miscompares++;
          $display("FAIL rand_invariant r%0d: long %0d > pend %0d", k, long_m[k], pend_m[k]);
        end
      end
      tick();
    end
  endtask

  initial begin
    resetn = 0;
    idle_inputs();
    rs1_re = 0; rs1 = 0; rs2_re = 0; rs2 = 0;
    test_reset();
    test_load_stall();
    test_short_write();
    test_r0();
    test_saturation();
    test_same_cycle();
    test_flush_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
